// File: rtl/output_scheduler.sv
// Round-robin scheduler sharing one serial emitter between NUM_REQ requesters.
// Latches the granted word, then runs the LOAD / EMIT / GAP handshake on emit_ready.
module output_scheduler #(
    parameter int unsigned OUTPUT_WIDTH = 16,
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned GAP_CYCLES   = 1,
    localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            fast_clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*OUTPUT_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]              grant,
    output logic [NUM_REQ-1:0]              done,
    output logic [OUTPUT_WIDTH-1:0]         emit_data,
    output logic                            emit_ready,
    output logic                            busy,
    output logic [OW-1:0]                   owner
);

    localparam int unsigned HOLD = OUTPUT_WIDTH + 1;
    localparam int unsigned HW   = $clog2(OUTPUT_WIDTH + 2);
    localparam int unsigned GW   = $clog2(GAP_CYCLES + 1);
    localparam int unsigned CW   = (HW > GW) ? HW : GW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EMIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t            state;
    logic [OW-1:0]     ptr;
    logic [CW-1:0]     cnt;
    logic              pick_valid_c;
    logic [OW-1:0]     pick_idx_c;
    logic [OUTPUT_WIDTH-1:0] pick_data_c;

    // First asserted request at or above the pointer, wrapping around.
    always_comb begin
        int unsigned idx;
        pick_valid_c = 1'b0;
        pick_idx_c   = '0;
        idx          = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!pick_valid_c && req[OW'(idx)]) begin
                pick_valid_c = 1'b1;
                pick_idx_c   = OW'(idx);
            end
        end
    end

    always_comb begin
        pick_data_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (OW'(i) == pick_idx_c) begin
                pick_data_c = req_data[i*OUTPUT_WIDTH +: OUTPUT_WIDTH];
            end
        end
    end

    always_ff @(posedge fast_clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            cnt        <= '0;
            grant      <= '0;
            done       <= '0;
            emit_data  <= '0;
            emit_ready <= 1'b0;
            busy       <= 1'b0;
            owner      <= '0;
        end else begin
            done <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_valid_c) begin
                        grant     <= NUM_REQ'(1) << pick_idx_c;
                        owner     <= pick_idx_c;
                        busy      <= 1'b1;
                        emit_data <= pick_data_c;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    emit_ready <= 1'b1;
                    cnt        <= '0;
                    state      <= S_EMIT;
                end
                S_EMIT: begin
                    if (cnt == CW'(HOLD - 1)) begin
                        emit_ready <= 1'b0;
                        grant      <= '0;
                        done       <= grant;
                        ptr        <= (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);
                        cnt        <= '0;
                        state      <= S_GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    // Idle gap lets the emitter clear its bit counter.
                    if (cnt == CW'(GAP_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_scheduler.sv
// Directed bench for output_scheduler: timing, round-robin order, data hold, and reset abort.
module tb_output_scheduler;

    localparam int unsigned W = 16;
    localparam int unsigned N = 4;

    logic           fast_clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [W-1:0]   emit_data;
    logic           emit_ready;
    logic           busy;
    logic [1:0]     owner;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    output_scheduler #(.OUTPUT_WIDTH(W), .NUM_REQ(N), .GAP_CYCLES(1)) dut (
        .fast_clk   (fast_clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .grant      (grant),
        .done       (done),
        .emit_data  (emit_data),
        .emit_ready (emit_ready),
        .busy       (busy),
        .owner      (owner)
    );

    always #5 fast_clk = ~fast_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge fast_clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Waits for the current grant to end, then for the next one to appear.
    task automatic next_grant(output logic [N-1:0] g);
        int t = 0;
        while (grant != '0 && t < 100) begin step(); t++; end
        while (grant == '0 && t < 100) begin step(); t++; end
        g = grant;
    endtask

    initial begin
        int ones, dones, done_cyc, bad, busy20, seen3;
        logic [N-1:0] g;

        reset    = 1'b0;
        req      = '0;
        req_data = '0;

        // Reset state
        do_reset();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_data", 32'(emit_data), 32'h0);
        check("rst_ready", 32'(emit_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);

        // Single transfer on requester 0
        req_data[0*W +: W] = 16'hA5C3;
        req = 4'b0001;
        cyc = 0;
        step();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_owner", 32'(owner), 32'h0);
        check("t1_data", 32'(emit_data), 32'hA5C3);
        check("t1_ready_load", 32'(emit_ready), 32'h0);
        check("t1_busy", 32'(busy), 32'h1);
        req  = '0;
        ones = 0;
        while (cyc < 18) begin
            step();
            if (emit_ready) ones++;
        end
        check("t1_ready_cycles", 32'(ones), 32'd17);
        step();
        check("t1_done", 32'(done), 32'h1);
        check("t1_ready_off", 32'(emit_ready), 32'h0);
        check("t1_grant_off", 32'(grant), 32'h0);
        check("t1_busy_gap", 32'(busy), 32'h1);
        step();
        check("t1_busy_idle", 32'(busy), 32'h0);
        check("t1_done_pulse", 32'(done), 32'h0);

        // All requesters held: grants rotate every 20 cycles
        do_reset();
        req = 4'b1111;
        cyc = 0;
        bad = 0;
        while (cyc < 81) begin
            step();
            if (!$onehot0(grant) || !$onehot0(done) || (grant != '0 && done != '0)) bad++;
            case (cyc)
                1:  check("t2_grant_c1", 32'(grant), 32'h1);
                20: check("t2_gap_c20", 32'(grant), 32'h0);
                21: check("t2_grant_c21", 32'(grant), 32'h2);
                41: check("t2_grant_c41", 32'(grant), 32'h4);
                61: check("t2_grant_c61", 32'(grant), 32'h8);
                81: check("t2_grant_c81", 32'(grant), 32'h1);
                default: ;
            endcase
        end
        check("t2_onehot", 32'(bad), 32'd0);

        // Serve requester 2 so pointer=3, then 0 and 2 compete
        do_reset();
        req = 4'b0100;
        cyc = 0;
        step();
        check("t3_grant2", 32'(grant), 32'h4);
        req = '0;
        while (cyc < 20) step();
        check("t3_idle", 32'(busy), 32'h0);
        req   = 4'b0101;
        seen3 = 0;
        while (cyc < 61) begin
            step();
            if (grant[3]) seen3++;
            if (cyc == 21) begin
                check("t3_grant_wrap", 32'(grant), 32'h1);
                check("t3_owner_wrap", 32'(owner), 32'h0);
            end
            if (cyc == 41) begin
                check("t3_grant_next", 32'(grant), 32'h4);
                check("t3_owner_next", 32'(owner), 32'h2);
            end
        end
        check("t3_never3", 32'(seen3), 32'd0);

        // Request dropped mid-EMIT: transfer still completes
        do_reset();
        req = 4'b0010;
        cyc = 0;
        ones = 0; dones = 0; done_cyc = -1; busy20 = -1;
        while (cyc < 25) begin
            step();
            if (cyc == 1) check("t4_owner", 32'(owner), 32'h1);
            if (cyc == 6) req = '0;
            if (emit_ready) ones++;
            if (done == 4'b0010) begin dones++; done_cyc = cyc; end
            if (cyc == 20) busy20 = int'(busy);
        end
        check("t4_ready_cycles", 32'(ones), 32'd17);
        check("t4_done_count", 32'(dones), 32'd1);
        check("t4_done_cycle", 32'(done_cyc), 32'd19);
        check("t4_idle", 32'(busy20), 32'd0);

        // req_data changes after capture are ignored
        do_reset();
        req_data[2*W +: W] = 16'h1234;
        req = 4'b0100;
        cyc = 0;
        bad = 0;
        while (cyc < 25) begin
            step();
            if (cyc == 1) req = '0;
            if (cyc == 8) req_data[2*W +: W] = 16'hFFFF;
            if (emit_data != 16'h1234) bad++;
        end
        check("t5_data_hold", 32'(bad), 32'd0);
        check("t5_data_end", 32'(emit_data), 32'h1234);

        // Reset in mid-EMIT aborts the transfer and clears the pointer
        do_reset();
        req = 4'b0010;
        cyc = 0;
        step();
        req = '0;
        while (cyc < 20) step();
        req = 4'b0100;
        cyc = 0;
        step();
        check("t6_grant2", 32'(grant), 32'h4);
        req = '0;
        while (cyc < 11) step();
        reset = 1'b0;
        step();
        check("t6_ready", 32'(emit_ready), 32'h0);
        check("t6_grant", 32'(grant), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_done", 32'(done), 32'h0);
        step();
        check("t6_done_held", 32'(done), 32'h0);
        reset = 1'b1;
        req   = 4'b0110;
        next_grant(g);
        check("t6_regrant", 32'(g), 32'h2);
        req = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
